// File: rtl/alu_fifo_out_if.sv
// Bundle of the write, read and status signals between the ALU output control
// unit / host (master) and the result FIFO (slave).
interface alu_fifo_out_if #(
  parameter int FIFO_OUT_WIDTH = 40,
  parameter int ADDR_W         = 3
);
  logic                      w_en_out;
  logic [FIFO_OUT_WIDTH-1:0] fifo_res;
  logic                      ready_f_res;
  logic                      res_valid;
  logic [FIFO_OUT_WIDTH-1:0] res_data;
  logic                      res_ready;
  logic [ADDR_W:0]           count;
  logic                      almost_full;
  logic                      overflow_err;
  logic                      underflow_err;
  logic                      clear_err;

  modport master (
    output w_en_out, fifo_res, res_ready, clear_err,
    input  ready_f_res, res_valid, res_data, count, almost_full,
           overflow_err, underflow_err
  );

  modport slave (
    input  w_en_out, fifo_res, res_ready, clear_err,
    output ready_f_res, res_valid, res_data, count, almost_full,
           overflow_err, underflow_err
  );
endinterface

// File: rtl/alu_fifo_out.sv
// Result FIFO behind the ALU output control unit. Stores {ID, result} words and
// presents the oldest one on a first-word-fall-through valid/ready read port,
// with occupancy, almost-full and sticky overflow/underflow status.
module alu_fifo_out #(
  parameter int FIFO_OUT_WIDTH = 40,
  parameter int DEPTH          = 8,
  parameter int ADDR_W         = 3,
  parameter int AFULL_THRESH   = 6
) (
  input logic           clk,
  input logic           rst,
  alu_fifo_out_if.slave bus
);

  localparam logic [ADDR_W:0]   FULL_CNT = (ADDR_W + 1)'(DEPTH);
  localparam logic [ADDR_W:0]   AF_CNT   = (ADDR_W + 1)'(AFULL_THRESH);
  localparam logic [ADDR_W:0]   CNT_ONE  = (ADDR_W + 1)'(1);
  localparam logic [ADDR_W-1:0] PTR_ONE  = ADDR_W'(1);

  logic [FIFO_OUT_WIDTH-1:0] mem [DEPTH];

  logic [ADDR_W-1:0] wr_ptr_reg, wr_ptr_next;
  logic [ADDR_W-1:0] rd_ptr_reg, rd_ptr_next;
  logic [ADDR_W:0]   count_reg, count_next;
  logic              overflow_reg, overflow_next;
  logic              underflow_reg, underflow_next;

  logic full;
  logic empty;
  logic push;
  logic pop;

  // Status decoded purely from registered occupancy, so ready_f_res never
  // depends combinationally on the handshake inputs.
  assign full  = (count_reg == FULL_CNT);
  assign empty = (count_reg == '0);
  assign push  = bus.w_en_out & ~full;
  assign pop   = bus.res_ready & ~empty;

  assign bus.ready_f_res   = ~full;
  assign bus.res_valid     = ~empty;
  assign bus.res_data      = empty ? '0 : mem[rd_ptr_reg];
  assign bus.count         = count_reg;
  assign bus.almost_full   = (count_reg >= AF_CNT);
  assign bus.overflow_err  = overflow_reg;
  assign bus.underflow_err = underflow_reg;

  // Next-state for pointers, occupancy and sticky flags; a set event beats clear.
  always_comb begin
    wr_ptr_next    = wr_ptr_reg;
    rd_ptr_next    = rd_ptr_reg;
    count_next     = count_reg;
    overflow_next  = overflow_reg;
    underflow_next = underflow_reg;

    if (push) wr_ptr_next = wr_ptr_reg + PTR_ONE;
    if (pop)  rd_ptr_next = rd_ptr_reg + PTR_ONE;

    if (push && !pop)      count_next = count_reg + CNT_ONE;
    else if (pop && !push) count_next = count_reg - CNT_ONE;

    if (bus.clear_err) begin
      overflow_next  = 1'b0;
      underflow_next = 1'b0;
    end
    if (bus.w_en_out && full)   overflow_next  = 1'b1;
    if (bus.res_ready && empty) underflow_next = 1'b1;
  end

  // Control state register with synchronous reset; stored words are discarded
  // simply by zeroing the pointers and occupancy.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_reg    <= '0;
      rd_ptr_reg    <= '0;
      count_reg     <= '0;
      overflow_reg  <= 1'b0;
      underflow_reg <= 1'b0;
    end else begin
      wr_ptr_reg    <= wr_ptr_next;
      rd_ptr_reg    <= rd_ptr_next;
      count_reg     <= count_next;
      overflow_reg  <= overflow_next;
      underflow_reg <= underflow_next;
    end
  end

  // Storage array; only written on an accepted push and never reset. The read
  // is asynchronous so a word is visible the cycle after it is written.
  always_ff @(posedge clk) begin
    if (push && !rst) mem[wr_ptr_reg] <= bus.fifo_res;
  end

endmodule

// File: tb/tb_alu_fifo_out.sv
// Self-checking bench for alu_fifo_out: directed scenarios followed by random
// traffic, all compared against a queue-based reference model each cycle.
module tb_alu_fifo_out;

  localparam int W     = 40;
  localparam int DEPTH = 8;
  localparam int AF    = 6;

  logic clk = 1'b0;
  logic rst;

  always #5 clk = ~clk;

  alu_fifo_out_if #(.FIFO_OUT_WIDTH(W), .ADDR_W(3)) bus_if ();

  alu_fifo_out #(
    .FIFO_OUT_WIDTH(W),
    .DEPTH(DEPTH),
    .ADDR_W(3),
    .AFULL_THRESH(AF)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus_if)
  );

  // Reference model state
  logic [W-1:0] q[$];
  logic         m_ovf;
  logic         m_udf;

  int total = 0;
  int bad   = 0;

  // Word popped on the most recent step (taken from the DUT before the edge)
  logic         popped;
  logic [W-1:0] popped_data;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    assert (got === exp) else begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      $error("check %s", tag);
    end
  endtask

  task automatic check_all();
    logic [W-1:0] exp_data;
    exp_data = (q.size() != 0) ? q[0] : '0;
    chk("ready_f_res",   64'(bus_if.ready_f_res),   64'(q.size() != DEPTH));
    chk("res_valid",     64'(bus_if.res_valid),     64'(q.size() != 0));
    chk("res_data",      64'(bus_if.res_data),      64'(exp_data));
    chk("count",         64'(bus_if.count),         64'(q.size()));
    chk("almost_full",   64'(bus_if.almost_full),   64'(q.size() >= AF));
    chk("overflow_err",  64'(bus_if.overflow_err),  64'(m_ovf));
    chk("underflow_err", 64'(bus_if.underflow_err), 64'(m_udf));
  endtask

  // One clock: drive inputs, advance, update the model, compare everything.
  task automatic step(input logic r, input logic w, input logic [W-1:0] d,
                      input logic rr, input logic clr);
    bit full_now, empty_now;
    rst              = r;
    bus_if.w_en_out  = w;
    bus_if.fifo_res  = d;
    bus_if.res_ready = rr;
    bus_if.clear_err = clr;
    #1;
    popped      = rr && bus_if.res_valid;
    popped_data = bus_if.res_data;
    @(posedge clk);
    if (r) begin
      q.delete();
      m_ovf = 1'b0;
      m_udf = 1'b0;
      popped = 1'b0;
    end else begin
      full_now  = (q.size() == DEPTH);
      empty_now = (q.size() == 0);
      if (clr) begin
        m_ovf = 1'b0;
        m_udf = 1'b0;
      end
      if (w && full_now)  m_ovf = 1'b1;
      if (rr && empty_now) m_udf = 1'b1;
      if (rr && !empty_now) void'(q.pop_front());
      if (w && !full_now)   q.push_back(d);
    end
    #1;
    check_all();
  endtask

  function automatic logic [W-1:0] word(input int id);
    return {8'(id), 32'h0000_1000 + 32'(id)};
  endfunction

  initial begin
    int next_id;
    int exp_rd;
    int budget;
    logic rr_t;
    logic [W-1:0] rd;

    rst = 1'b1;
    bus_if.w_en_out  = 1'b0;
    bus_if.fifo_res  = '0;
    bus_if.res_ready = 1'b0;
    bus_if.clear_err = 1'b0;
    m_ovf = 1'b0;
    m_udf = 1'b0;

    // Reset then idle
    step(1, 0, '0, 0, 0);
    step(1, 0, '0, 0, 0);
    step(0, 0, '0, 0, 0);
    chk("reset_data", 64'(bus_if.res_data), 64'd0);

    // Single write, then single read
    step(0, 1, 40'h01_0000_00AA, 0, 0);
    chk("single_data", 64'(bus_if.res_data), 64'h01_0000_00AA);
    chk("single_cnt", 64'(bus_if.count), 64'd1);
    step(0, 0, '0, 1, 0);
    chk("single_pop_valid", 64'(bus_if.res_valid), 64'd0);

    // Fill to full, then overflow
    for (int i = 0; i < 8; i++) begin
      step(0, 1, word(i), 0, 0);
      if (i == 4) chk("af_below", 64'(bus_if.almost_full), 64'd0);
      if (i == 5) chk("af_rise", 64'(bus_if.almost_full), 64'd1);
    end
    chk("full_ready", 64'(bus_if.ready_f_res), 64'd0);
    step(0, 1, word(8), 0, 0);
    chk("ovf_flag", 64'(bus_if.overflow_err), 64'd1);
    chk("ovf_cnt", 64'(bus_if.count), 64'd8);
    chk("ovf_head_id", 64'(bus_if.res_data[39:32]), 64'd0);

    // Full with push+pop: only pop happens; then push+pop keeps count
    step(0, 1, word(9), 1, 0);
    chk("fullpp_cnt", 64'(bus_if.count), 64'd7);
    step(0, 1, word(10), 1, 0);
    chk("pp_cnt", 64'(bus_if.count), 64'd7);
    step(0, 0, '0, 0, 1);
    chk("ovf_clear", 64'(bus_if.overflow_err), 64'd0);
    budget = 0;
    while (bus_if.res_valid && budget < 20) begin
      step(0, 0, '0, 1, 0);
      budget++;
    end
    chk("drained", 64'(bus_if.count), 64'd0);

    // Stream 20 words with res_ready toggling; checks order and wrap-around
    next_id = 0;
    exp_rd  = 0;
    rr_t    = 1'b0;
    budget  = 0;
    while (exp_rd < 20 && budget < 200) begin
      step(0, (next_id < 20) && (q.size() < DEPTH), word(next_id), rr_t, 0);
      if (q.size() > 0 && q[$] == word(next_id) && next_id < 20) next_id++;
      if (popped) begin
        chk("stream_order", 64'(popped_data), 64'(word(exp_rd)));
        exp_rd++;
      end
      rr_t = ~rr_t;
      budget++;
    end
    chk("stream_done", 64'(exp_rd), 64'd20);
    chk("stream_no_ovf", 64'(bus_if.overflow_err), 64'd0);
    chk("stream_no_udf", 64'(bus_if.underflow_err), 64'd0);

    // Underflow and clear
    step(0, 0, '0, 1, 0);
    chk("udf_set", 64'(bus_if.underflow_err), 64'd1);
    step(0, 0, '0, 1, 1);
    chk("udf_set_beats_clear", 64'(bus_if.underflow_err), 64'd1);
    step(0, 0, '0, 0, 1);
    chk("udf_clear", 64'(bus_if.underflow_err), 64'd0);

    // Mid-operation reset with 5 words stored
    for (int i = 0; i < 5; i++) step(0, 1, word(32 + i), 0, 0);
    step(1, 0, '0, 0, 0);
    chk("mrst_cnt", 64'(bus_if.count), 64'd0);
    chk("mrst_valid", 64'(bus_if.res_valid), 64'd0);
    chk("mrst_ready", 64'(bus_if.ready_f_res), 64'd1);
    step(0, 1, word(50), 0, 0);
    step(0, 1, word(51), 0, 0);
    step(0, 0, '0, 1, 0);
    chk("post_rst_rd0", 64'(popped_data), 64'(word(50)));
    step(0, 0, '0, 1, 0);
    chk("post_rst_rd1", 64'(popped_data), 64'(word(51)));

    // Random traffic against the model
    for (int n = 0; n < 600; n++) begin
      rd = {8'($urandom), 32'($urandom)};
      step(($urandom_range(0, 99) == 0),
           ($urandom_range(0, 99) < 60),
           rd,
           ($urandom_range(0, 99) < 45),
           ($urandom_range(0, 19) == 0));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/alu_fifo_out.md
Name: alu_fifo_out

Overview:
Output result FIFO sitting directly downstream of the ALU output control unit. It buffers {ID, result} words written via w_en_out/fifo_res and returns backpressure on ready_f_res. It presents stored words to the host read side through a first-word-fall-through valid/ready interface. It also keeps occupancy, almost-full and sticky error status.

Parameters:
FIFO_OUT_WIDTH, 40, stored word width (8-bit ID + 32-bit result)
DEPTH, 8, number of entries; power of two, minimum 2
ADDR_W, 3, pointer width, equal to log2(DEPTH)
AFULL_THRESH, 6, count at or above which almost_full asserts; range 1..DEPTH

Ports:
clk  in  1  clock, all logic on rising edge
rst  in  1  synchronous active-high reset
w_en_out  in  1  write strobe from output control unit
fifo_res  in  FIFO_OUT_WIDTH  word to store
ready_f_res  out  1  FIFO can accept a write this cycle
res_valid  out  1  res_data holds the oldest stored word
res_data  out  FIFO_OUT_WIDTH  oldest word; 0 when empty
res_ready  in  1  host accepts res_data
count  out  ADDR_W+1  current occupancy, 0..DEPTH
almost_full  out  1  count >= AFULL_THRESH
overflow_err  out  1  sticky: write attempted while full
underflow_err  out  1  sticky: res_ready high while empty
clear_err  in  1  clears both sticky flags

Behaviour:
- Reset (rst high at a clock edge): wr_ptr=0, rd_ptr=0, count=0, overflow_err=0, underflow_err=0. As a result ready_f_res=1, res_valid=0, res_data=0, almost_full=0. Memory contents are not reset.
- A reset asserted mid-operation discards all stored words on that edge. No partial state remains.
- ready_f_res = (count != DEPTH). It is decoded from registered count only, with no combinational path from res_ready or w_en_out.
- push = w_en_out & ready_f_res. On push, mem[wr_ptr] <= fifo_res and wr_ptr increments.
- pop = res_valid & res_ready. On pop, rd_ptr increments.
- Pointers wrap from DEPTH-1 to 0 by natural ADDR_W-bit rollover.
- count update: push only -> +1; pop only -> -1; both or neither -> unchanged.
- Simultaneous push and pop when full: push is blocked because ready_f_res=0. Pop proceeds, and count becomes DEPTH-1 the next cycle.
- Simultaneous push and pop when empty: pop is impossible because res_valid=0. The push completes.
- FWFT read side:
  - res_valid = (count != 0).
  - res_data = mem[rd_ptr] when res_valid, otherwise 0.
  - A word written at edge N is visible on res_data/res_valid after edge N, i.e. 1-cycle write-to-read latency.
  - res_data and res_valid must stay stable while res_valid=1 and res_ready=0.
- almost_full = (count >= AFULL_THRESH), decoded from registered count.
- overflow_err: set on the edge where w_en_out=1 and count==DEPTH. The write is dropped and FIFO state is unchanged.
- underflow_err: set on the edge where res_ready=1 and count==0. There is no state change.
- clear_err=1 clears both flags on that edge. If clear_err and a new set event occur on the same edge, the set event wins (flag stays 1).
- Word ordering is strictly first-in first-out. No word is duplicated or lost except a write dropped under overflow.

Test Plan:
- Reset then idle -> ready_f_res=1, res_valid=0, res_data=0, count=0, both error flags 0.
- Single write fifo_res=40'h01_0000_00AA at edge N with res_ready=0:
  - after edge N, res_valid=1, res_data=40'h01_0000_00AA, count=1;
  - then res_ready=1 for one cycle -> res_valid=0, count=0.
- Write 8 words ID 0..7 with no reads:
  - almost_full rises after the 6th write;
  - ready_f_res=0 and count=8 after the 8th write;
  - a 9th w_en_out -> overflow_err=1, count stays 8, res_data still ID 0.
- Full FIFO, w_en_out=1 and res_ready=1 together:
  - only the pop occurs, count=7, ready_f_res=1;
  - on the next cycle push and pop together -> count stays 7.
- Stream 20 words (IDs 0..19) with res_ready toggling 1,0,1,0:
  - read sequence is exactly 0..19, exercising wrap-around;
  - no errors.
- Error handling and mid-operation reset:
  - res_ready=1 while empty -> underflow_err=1;
  - clear_err=1 -> underflow_err=0;
  - with 5 words stored, assert rst for one edge -> count=0, res_valid=0, ready_f_res=1, and subsequent reads return only post-reset words.
